instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Single-cycle fetch/next-PC stage directly upstream of datapath. Holds PC, drives
//  instruction-memory address, splits the fetched word into Rs/Rt/Rd/imm16 for the
//  datapath, resolves BEQ/BNE/J/JAL/JR using datapath Alu_zero and Da, and supplies
//  the JAL link address. Run/halt FSM stops fetch on HALT opcode or misaligned target.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset (must be word aligned)
//  HALT_OP    6'h3F          opcode that halts the unit
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous, active-low reset
//  stall        in   1   1 = hold PC, state and count this cycle
//  imem_addr    out  32  byte address of instruction (= PC)
//  imem_data    in   32  instruction word, combinational read of imem_addr
//  Alu_zero     in   1   datapath ALU zero flag for current instruction
//  Da           in   32  datapath register Rs read value (JR target)
//  opcode       out  6   imem_data[31:26]
//  funct        out  6   imem_data[5:0]
//  Rs/Rt/Rd     out  5   imem_data[25:21]/[20:16]/[15:11]
//  R31          out  5   constant 5'd31
//  imm16        out  16  imem_data[15:0]
//  link_addr    out  32  PC+4 (JAL write-back value)
//  instr_count  out  32  instructions retired since reset
//  halted       out  1   1 = FSM in HALT
//  fault        out  1   1 = halted due to misaligned next PC
// BEHAVIOUR
//  - Reset (async, reset_n=0): PC=RESET_PC, state=RUN, instr_count=0, halted=0,
//    fault=0. Release is synchronous to next clk edge; reset mid-run aborts instantly.
//  - Field outputs, link_addr, imem_addr: combinational from PC/imem_data, zero latency.
//  - FSM states RUN, HALT. In HALT PC/count frozen; only reset exits.
//  - Per clk edge in RUN with stall=0 (one instruction retires):
//    * opcode==HALT_OP: PC unchanged, -> HALT, halted=1, count NOT incremented.
//    * else next PC chosen, count+1 (wraps 32'hFFFF_FFFF -> 0):
//      BEQ 6'h04 & Alu_zero   : PC+4 + (sext(imm16)<<2)
//      BNE 6'h05 & !Alu_zero  : PC+4 + (sext(imm16)<<2)
//      J 6'h02 / JAL 6'h03    : {PC+4[31:28], imm_data[25:0], 2'b00}
//      JR opcode 0, funct 6'h08: Da
//      otherwise              : PC+4
//    * all adds modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.
//    * if selected next PC[1:0]!=0: PC unchanged, -> HALT, halted=1, fault=1,
//      count still incremented (instruction retired, target rejected).
//  - stall=1: no PC, state or count change; HALT_OP/fault only act when stall=0.
//  - Not-taken branch behaves as PC+4. Backward branch uses negative sext offset.
// TESTING
//  1 Reset: reset_n=0 mid-run -> PC=0, instr_count=0, halted=0 without clk edge.
//  2 Sequential: 3 ADD words at 0,4,8 -> PC 0->4->8->C, instr_count=3.
//  3 BEQ at PC=0x10, imm16=16'hFFFC, Alu_zero=1 -> PC=0x04; Alu_zero=0 -> PC=0x14.
//  4 JAL at PC=0x20, target26=0x40 -> link_addr=0x24, next PC=0x100, R31=31.
//  5 JR with Da=0x0000_0102 -> PC held, halted=1, fault=1; Da=0x200 -> PC=0x200.
//  6 HALT_OP at 0x30 with stall=1 two cycles -> RUN held; stall=0 -> halted=1, count frozen.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-cycle fetch / next-PC stage with run/halt control
//
// Purpose:
//   Holds the PC and drives the instruction-memory address. Splits the fetched
//   word into datapath fields. Resolves BEQ/BNE/J/JAL/JR using the datapath
//   Alu_zero flag and the Rs read value Da. Supplies the JAL link address.
//   A two-state run/halt FSM stops fetch on HALT_OP or on a misaligned next PC.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   stall              1 = hold PC, state and count this cycle
//   imem_addr          byte address of the current instruction (= PC)
//   imem_data          instruction word (combinational read of imem_addr)
//   Alu_zero, Da       datapath zero flag and Rs read value (JR target)
//   opcode, funct      imem_data[31:26], imem_data[5:0]
//   Rs, Rt, Rd         imem_data[25:21], [20:16], [15:11]
//   R31                constant 5'd31 (JAL destination)
//   imm16              imem_data[15:0]
//   link_addr          PC+4
//   instr_count        instructions retired since reset
//   halted, fault      FSM in HALT / halted because of a misaligned target
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        Alu_zero,
    input  logic [31:0] Da,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  R31,
    output logic [15:0] imm16,
    output logic [31:0] link_addr,
    output logic [31:0] instr_count,
    output logic        halted,
    output logic        fault
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] count, count_nxt;
    logic        fault_q, fault_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;

    // Field decode is purely combinational so the datapath sees it in the same cycle.
    assign opcode      = imem_data[31:26];
    assign Rs          = imem_data[25:21];
    assign Rt          = imem_data[20:16];
    assign Rd          = imem_data[15:11];
    assign imm16       = imem_data[15:0];
    assign funct       = imem_data[5:0];
    assign R31         = 5'd31;
    assign imem_addr   = pc;
    assign link_addr   = pc_plus4;
    assign instr_count = count;
    assign halted      = (state == ST_HALT);
    assign fault       = fault_q;

    // All arithmetic is modulo 2^32; PC+4 from 0xFFFF_FFFC wraps to 0.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {{14{imem_data[15]}}, imem_data[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], imem_data[25:0], 2'b00};

    always_comb begin
        target = pc_plus4;
        if ((opcode == OP_BEQ) && Alu_zero) begin
            target = branch_target;
        end else if ((opcode == OP_BNE) && !Alu_zero) begin
            target = branch_target;
        end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            target = jump_target;
        end else if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
            target = Da;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        count_nxt = count;
        fault_nxt = fault_q;
        if ((state == ST_RUN) && !stall) begin
            if (opcode == HALT_OP) begin
                // HALT does not retire: PC and count stay put.
                state_nxt = ST_HALT;
            end else begin
                count_nxt = count + 32'd1;
                // A misaligned target still retires the instruction but is never loaded.
                if (target[1:0] != 2'b00) begin
                    state_nxt = ST_HALT;
                    fault_nxt = 1'b1;
                end else begin
                    pc_nxt = target;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            count   <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            count   <= count_nxt;
            fault_q <= fault_nxt;
        end
    end

endmodule
